// File: rtl/buff_load_sched.sv
// Round-robin load scheduler: shares one 64-bit beat stream between the
// weight-sign and ifm buffer write controllers, one granted load at a time.
module buff_load_sched #(
    parameter int Addr_Width = 16,
    parameter int Data_Width = 64,
    parameter int Cnt_Width  = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_req,
    input  logic [Addr_Width-1:0] w_addr_end,
    output logic                  w_gnt,
    output logic                  w_done,
    input  logic                  f_req,
    input  logic [Addr_Width-1:0] f_addr_end,
    output logic                  f_gnt,
    output logic                  f_done,
    input  logic                  s_valid,
    input  logic [Data_Width-1:0] s_data,
    output logic                  s_ready,
    output logic                  w_start,
    output logic                  f_start,
    output logic [Addr_Width-1:0] w_Addr_end,
    output logic [Addr_Width-1:0] f_Addr_end,
    output logic                  w_valid,
    output logic                  f_valid,
    output logic [Data_Width-1:0] w_datain,
    output logic [Data_Width-1:0] f_datain,
    input  logic                  w_ready,
    input  logic                  f_ready,
    input  logic                  w_finished,
    input  logic                  f_finished,
    output logic                  busy,
    output logic                  err,
    output logic [Cnt_Width-1:0]  beat_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_XFER,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_sel;
    logic                  r_rr;
    logic                  r_err;
    logic [Addr_Width-1:0] r_w_addr;
    logic [Addr_Width-1:0] r_f_addr;
    logic [Cnt_Width-1:0]  r_cnt;

    logic                  w_any;
    logic                  w_pick_f;
    logic [Addr_Width-1:0] w_sel_addr;
    logic                  w_zero;
    logic                  w_sel_ready;
    logic                  w_sel_fin;
    logic                  w_xfer;
    logic                  w_acc;

    assign w_any       = w_req | f_req;
    assign w_pick_f    = (w_req & f_req) ? r_rr : f_req;
    assign w_sel_addr  = r_sel ? r_f_addr : r_w_addr;
    assign w_zero      = ~|w_sel_addr[Addr_Width-1:4];
    assign w_sel_ready = r_sel ? f_ready : w_ready;
    assign w_sel_fin   = r_sel ? f_finished : w_finished;
    assign w_xfer      = (r_state == S_XFER);
    assign w_acc       = w_xfer & s_valid & w_sel_ready;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any) w_next = S_GRANT;
            S_GRANT: w_next = w_zero ? S_DONE : S_XFER;
            S_XFER:  if (w_acc & w_sel_fin) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // End address is captured on the sampling edge so it is stable
    // alongside the start pulse during GRANT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel    <= 1'b0;
            r_rr     <= 1'b0;
            r_err    <= 1'b0;
            r_w_addr <= '0;
            r_f_addr <= '0;
            r_cnt    <= '0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_sel <= w_pick_f;
                if (w_pick_f) r_f_addr <= f_addr_end;
                else          r_w_addr <= w_addr_end;
            end
            if (r_state == S_GRANT) begin
                r_cnt <= '0;
                if (w_zero) r_err <= 1'b1;
            end
            if (w_acc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            if (r_state == S_DONE) r_rr <= ~r_sel;
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign w_gnt      = busy & ~r_sel;
    assign f_gnt      = busy & r_sel;
    assign w_start    = (r_state == S_GRANT) & ~w_zero & ~r_sel;
    assign f_start    = (r_state == S_GRANT) & ~w_zero & r_sel;
    assign w_done     = (r_state == S_DONE) & ~r_sel;
    assign f_done     = (r_state == S_DONE) & r_sel;
    assign s_ready    = w_xfer & w_sel_ready;
    assign w_valid    = w_acc & ~r_sel;
    assign f_valid    = w_acc & r_sel;
    assign w_datain   = (w_xfer & ~r_sel) ? s_data : '0;
    assign f_datain   = (w_xfer & r_sel) ? s_data : '0;
    assign w_Addr_end = r_w_addr;
    assign f_Addr_end = r_f_addr;
    assign err        = r_err;
    assign beat_cnt   = r_cnt;

endmodule

// File: tb/tb_buff_load_sched.sv
// Randomized bench for buff_load_sched with a transaction-timing model
// and an ideal controller model that flags the last beat by count.
module tb_buff_load_sched;

    localparam int AW  = 16;
    localparam int DW  = 64;
    localparam int CW  = 21;
    localparam int BIG = 1 << 30;

    logic          clk, rst;
    logic          w_req, f_req, w_gnt, f_gnt, w_done, f_done;
    logic [AW-1:0] w_addr_end, f_addr_end, w_Addr_end, f_Addr_end;
    logic          s_valid, s_ready, w_start, f_start;
    logic [DW-1:0] s_data, w_datain, f_datain;
    logic          w_valid, f_valid, w_ready, f_ready;
    logic          w_finished, f_finished, busy, err;
    logic [CW-1:0] beat_cnt;

    buff_load_sched #(.Addr_Width(AW), .Data_Width(DW), .Cnt_Width(CW)) dut (
        .clk(clk), .rst(rst),
        .w_req(w_req), .w_addr_end(w_addr_end), .w_gnt(w_gnt), .w_done(w_done),
        .f_req(f_req), .f_addr_end(f_addr_end), .f_gnt(f_gnt), .f_done(f_done),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .w_start(w_start), .f_start(f_start),
        .w_Addr_end(w_Addr_end), .f_Addr_end(f_Addr_end),
        .w_valid(w_valid), .f_valid(f_valid),
        .w_datain(w_datain), .f_datain(f_datain),
        .w_ready(w_ready), .f_ready(f_ready),
        .w_finished(w_finished), .f_finished(f_finished),
        .busy(busy), .err(err), .beat_cnt(beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk, nerr;
    int cyc, side, grant_cyc, done_cyc, free_cyc, len, mcnt, ndone;
    int pv, pr, wst_cnt, wbeats, fout_cnt;
    bit rr, merr;
    logic [AW-1:0] lat[2];
    int gq[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_xfer();
        return side >= 0 && cyc > grant_cyc && cyc < done_cyc;
    endfunction

    task automatic model_reset();
        side = -1; grant_cyc = -10; done_cyc = BIG; free_cyc = 0;
        len = 0; mcnt = 0; rr = 0; merr = 0;
        lat[0] = '0; lat[1] = '0;
        gq.delete();
    endtask

    task automatic check_outputs(input bit xf);
        bit rdy;
        rdy = (side == 1) ? f_ready : w_ready;
        chk("busy", busy, side >= 0);
        chk("w_gnt", w_gnt, side == 0);
        chk("f_gnt", f_gnt, side == 1);
        chk("w_start", w_start, side == 0 && cyc == grant_cyc && len > 0);
        chk("f_start", f_start, side == 1 && cyc == grant_cyc && len > 0);
        chk("w_done", w_done, side == 0 && cyc == done_cyc);
        chk("f_done", f_done, side == 1 && cyc == done_cyc);
        chk("err", err, merr);
        chk("s_ready", s_ready, xf ? rdy : 1'b0);
        chk("w_valid", w_valid, (xf && side == 0) ? (s_valid & w_ready) : 1'b0);
        chk("f_valid", f_valid, (xf && side == 1) ? (s_valid & f_ready) : 1'b0);
        if (xf) begin
            chk("w_datain", w_datain, side == 0 ? s_data : '0);
            chk("f_datain", f_datain, side == 1 ? s_data : '0);
        end
        if (side < 0 || cyc > grant_cyc) chk("beat_cnt", beat_cnt, mcnt);
        if (!(side == 0 && cyc == grant_cyc)) chk("w_Addr_end", w_Addr_end, lat[0]);
        if (!(side == 1 && cyc == grant_cyc)) chk("f_Addr_end", f_Addr_end, lat[1]);
        if (w_start) wst_cnt++;
        if (w_valid) wbeats++;
        if (f_valid || f_start || f_gnt || f_datain != '0) fout_cnt++;
    endtask

    task automatic model_update(input bit xf);
        bit rdy, fin;
        int s;
        rdy = (side == 1) ? f_ready : w_ready;
        if (xf && s_valid && rdy) begin
            fin = (mcnt == len * 32 - 1);
            if (mcnt < (1 << CW) - 1) mcnt++;
            if (fin) done_cyc = cyc + 1;
        end
        if (side >= 0 && cyc == grant_cyc) begin
            mcnt = 0;
            if (len == 0) merr = 1;
        end
        if (side >= 0 && cyc == done_cyc) begin
            rr = (side == 0);
            side = -1;
            free_cyc = cyc + 1;
            ndone++;
        end
        if (side < 0 && cyc >= free_cyc && (w_req || f_req)) begin
            s = (w_req && f_req) ? int'(rr) : (f_req ? 1 : 0);
            side = s;
            grant_cyc = cyc + 1;
            lat[s] = s ? f_addr_end : w_addr_end;
            len = int'(lat[s] >> 4);
            done_cyc = (len == 0) ? cyc + 2 : BIG;
            gq.push_back(s);
        end
    endtask

    // Called just after a rising edge; drives one cycle and checks it.
    task automatic cycle();
        bit xf;
        s_valid = ($urandom_range(0, 99) < pv);
        s_data  = {$urandom(), $urandom()};
        w_ready = ($urandom_range(0, 99) < pr);
        f_ready = ($urandom_range(0, 99) < pr);
        xf = in_xfer();
        w_finished = xf && side == 0 && mcnt == len * 32 - 1;
        f_finished = xf && side == 1 && mcnt == len * 32 - 1;
        @(negedge clk);
        check_outputs(xf);
        model_update(xf);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int target, input int maxc);
        int k;
        int base;
        k = 0;
        base = ndone;
        while (k < maxc && !(ndone - base >= target && side < 0)) begin
            if (ndone - base >= target) begin
                w_req = 0;
                f_req = 0;
            end
            cycle();
            k++;
        end
        chk("run_timeout", k < maxc, 1'b1);
        w_req = 0;
        f_req = 0;
        cycle();
        cycle();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #2 rst = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_gnt", {w_gnt, f_gnt}, 0);
        chk("rst_start", {w_start, f_start}, 0);
        chk("rst_done", {w_done, f_done}, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_valid", {w_valid, f_valid}, 0);
        chk("rst_w_datain", w_datain, 0);
        chk("rst_f_datain", f_datain, 0);
        chk("rst_addr", {w_Addr_end, f_Addr_end}, 0);
        chk("rst_err", err, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        w_req = 0; f_req = 0; w_finished = 0; f_finished = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        cyc += 2;
        rst = 1;
    endtask

    initial begin
        int k;
        nchk = 0; nerr = 0; cyc = 0; ndone = 0;
        rst = 0; w_req = 0; f_req = 0; s_valid = 0; s_data = '0;
        w_ready = 0; f_ready = 0; w_finished = 0; f_finished = 0;
        w_addr_end = '0; f_addr_end = '0;
        pv = 100; pr = 100;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // single weight load of two 32-row blocks
        wst_cnt = 0; wbeats = 0; fout_cnt = 0;
        w_addr_end = 16'h0020;
        w_req = 1;
        run(1, 500);
        chk("single_beat_cnt", beat_cnt, 64);
        chk("single_w_start_pulses", wst_cnt, 1);
        chk("single_w_beats", wbeats, 64);
        chk("single_f_quiet", fout_cnt, 0);

        // contention with both requests held
        do_reset();
        w_addr_end = 16'h0010;
        f_addr_end = 16'h0010;
        w_req = 1; f_req = 1;
        run(3, 2000);
        chk("cont_ngrants", gq.size(), 3);
        if (gq.size() == 3) begin
            chk("cont_g0", gq[0], 0);
            chk("cont_g1", gq[1], 1);
            chk("cont_g2", gq[2], 0);
        end
        chk("cont_beat_cnt", beat_cnt, 32);

        // backpressure on both valid and ready
        pv = 60; pr = 60;
        wbeats = 0;
        w_req = 1;
        run(1, 2000);
        chk("bp_beat_cnt", beat_cnt, 32);
        chk("bp_w_beats", wbeats, 32);

        // randomized loads
        for (int i = 0; i < 6; i++) begin
            pv = $urandom_range(40, 100);
            pr = $urandom_range(40, 100);
            w_addr_end = 16'($urandom_range(16, 47));
            f_addr_end = 16'($urandom_range(16, 47));
            w_req = $urandom_range(0, 1);
            f_req = !w_req || ($urandom_range(0, 1) == 1);
            run(1, 3000);
        end

        // zero length on ifm side
        pv = 100; pr = 100;
        f_addr_end = 16'h000F;
        f_req = 1;
        run(1, 50);
        chk("zero_err", err, 1);
        w_addr_end = 16'h0010;
        w_req = 1;
        run(1, 500);
        chk("zero_err_sticky", err, 1);

        // reset mid-transfer
        w_addr_end = 16'h0020;
        w_req = 1;
        k = 0;
        while (k < 200 && !(side == 0 && in_xfer() && mcnt >= 10)) begin
            cycle();
            k++;
        end
        chk("midxfer_timeout", k < 200, 1'b1);
        do_reset();
        w_addr_end = 16'h0010;
        f_addr_end = 16'h0010;
        w_req = 1; f_req = 1;
        run(1, 500);
        chk("post_rst_first", gq.size() > 0 ? gq[0] : -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
